// File: rtl/latch_bank_4x8.sv
// Four-slot byte register bank with store-edge capture, valid flags and a scanned display output.
// Define LATCH_BANK_LOCK_EN for write-once slots and the extra wr_reject output.
module latch_bank_4x8 #(
    parameter int WIDTH    = 8,
    parameter int SCAN_DIV = 100000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       sel,
    input  logic             store,
    input  logic             clear,
    output logic [WIDTH-1:0] Q1,
    output logic [WIDTH-1:0] Q2,
    output logic [WIDTH-1:0] Q3,
    output logic [WIDTH-1:0] Q4,
    output logic [3:0]       valid,
    output logic             wr_ack,
`ifdef LATCH_BANK_LOCK_EN
    output logic             wr_reject,
`endif
    output logic [WIDTH-1:0] scan_data,
    output logic [1:0]       scan_idx
);

    localparam int CW = $clog2(SCAN_DIV + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [WIDTH-1:0] slot_q [4];
    logic [3:0]       valid_q;
    logic             store_q;
    logic             wr_ack_q;
    logic             wr_reject_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             wr_event;
    logic             accept;

    // clear suppresses the write but store_q still tracks store below
    always_comb begin
        wr_event = store & ~store_q & ~clear;
`ifdef LATCH_BANK_LOCK_EN
        accept   = wr_event & ~valid_q[sel];
`else
        accept   = wr_event;
`endif
    end

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) slot_q[i] <= '0;
            valid_q     <= '0;
            store_q     <= 1'b0;
            wr_ack_q    <= 1'b0;
            wr_reject_q <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
        end else begin
            store_q     <= store;
            wr_ack_q    <= accept;
            wr_reject_q <= wr_event & ~accept;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            if (clear) begin
                for (int i = 0; i < 4; i++) slot_q[i] <= '0;
                valid_q <= '0;
            end else if (accept) begin
                slot_q[sel]  <= data_in;
                valid_q[sel] <= 1'b1;
            end
        end
    end

    always_comb begin
        scan_data = slot_q[idx_q];
    end

    assign Q1       = slot_q[0];
    assign Q2       = slot_q[1];
    assign Q3       = slot_q[2];
    assign Q4       = slot_q[3];
    assign valid    = valid_q;
    assign wr_ack   = wr_ack_q;
    assign scan_idx = idx_q;
`ifdef LATCH_BANK_LOCK_EN
    assign wr_reject = wr_reject_q;
`else
    logic unused_reject;
    assign unused_reject = wr_reject_q;
`endif

endmodule
